// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled rx line, LSB-first byte recovery, valid/ready output
// with one-cycle frame_err and overrun pulses.
module uart_rx #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 921600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV + 1);

    typedef enum logic [2:0] {
        WAIT_HI,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rx_s;
    logic          deliver;

    assign rx_s      = sync_q[1];
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_HI;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[0], rx};
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            WAIT_HI: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CW'(HALF - 1);
                end
            end
            START: begin
                // Mid-start-bit check rejects short low glitches.
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        cnt_d     = CW'(DIV - 1);
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shreg_d[bit_idx_q] = rx_s;
                    cnt_d              = CW'(DIV - 1);
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = WAIT_HI;
            end
        endcase

        // A held byte is never overwritten; the new one is dropped instead.
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=10 / HALF=5: bytes, glitches, framing errors,
// overrun, same-cycle accept and mid-frame reset.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int         cyc = 0;
    logic [7:0] hs_q[$];
    int         rise_cyc   = 0;
    int         fe_total   = 0;
    int         ov_total   = 0;
    int         both_total = 0;
    int         stab_total = 0;
    logic       valid_prev = 1'b0;
    logic       ready_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;
    int         start_cyc  = 0;

    uart_rx #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: handshakes, pulse counts, data stability while stalled.
    always @(negedge clk) begin
        if (valid && ready) hs_q.push_back(data);
        if (valid && !valid_prev) rise_cyc = cyc;
        if (frame_err) fe_total = fe_total + 1;
        if (overrun) ov_total = ov_total + 1;
        if (frame_err && overrun) both_total = both_total + 1;
        if (valid && valid_prev && !ready_prev && data !== data_prev) stab_total = stab_total + 1;
        valid_prev = valid;
        ready_prev = ready;
        data_prev  = data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len,
                             input int ready_at);
        logic [7:0] bv;
        bv = b;
        start_cyc = cyc;
        for (int t = 0; t < 90 + stop_len; t++) begin
            if (t < 10) rx = 1'b0;
            else if (t < 90) rx = bv[(t - 10) / 10];
            else rx = stop_bit;
            if (t == ready_at) ready = 1'b1;
            else if (ready_at >= 0 && t == ready_at + 1) ready = 1'b0;
            tick();
        end
    endtask

    function automatic logic [7:0] hs_at(input int idx);
        if (idx < hs_q.size()) return hs_q[idx];
        return 8'hxx;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (3) tick();
        total_cnt++; if (data !== 8'h00) $display("FAIL reset_data got %h exp 00", data); else pass_cnt++;
        total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else pass_cnt++;
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_basic();
        int hs0, fe0, ov0, lat;
        hs0 = hs_q.size(); fe0 = fe_total; ov0 = ov_total;
        ready = 1'b1;
        send_byte(8'hA5, 1'b1, 10, -1);
        idle(20);
        lat = rise_cyc - start_cyc;
        total_cnt++; if (hs_q.size() - hs0 !== 1) $display("FAIL basic_count got %0d exp 1", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'hA5) $display("FAIL basic_data got %h exp a5", hs_at(hs0)); else pass_cnt++;
        total_cnt++; if (fe_total - fe0 !== 0) $display("FAIL basic_frame_err got %0d exp 0", fe_total - fe0); else pass_cnt++;
        total_cnt++; if (ov_total - ov0 !== 0) $display("FAIL basic_overrun got %0d exp 0", ov_total - ov0); else pass_cnt++;
        total_cnt++; if (lat < 98 || lat > 100) $display("FAIL basic_latency got %0d exp 98..100", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int hs0, fe0;
        hs0 = hs_q.size(); fe0 = fe_total;
        ready = 1'b1;
        send_byte(8'h00, 1'b1, 10, -1);
        send_byte(8'hFF, 1'b1, 10, -1);
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 2) $display("FAIL b2b_count got %0d exp 2", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'h00) $display("FAIL b2b_first got %h exp 00", hs_at(hs0)); else pass_cnt++;
        total_cnt++; if (hs_at(hs0 + 1) !== 8'hFF) $display("FAIL b2b_second got %h exp ff", hs_at(hs0 + 1)); else pass_cnt++;
        total_cnt++; if (fe_total - fe0 !== 0) $display("FAIL b2b_frame_err got %0d exp 0", fe_total - fe0); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int hs0, fe0;
        hs0 = hs_q.size(); fe0 = fe_total;
        ready = 1'b1;
        rx = 1'b0;
        repeat (3) tick();
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 0) $display("FAIL glitch_no_valid got %0d exp 0", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (fe_total - fe0 !== 0) $display("FAIL glitch_frame_err got %0d exp 0", fe_total - fe0); else pass_cnt++;
        send_byte(8'h3C, 1'b1, 10, -1);
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 1) $display("FAIL glitch_next_count got %0d exp 1", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'h3C) $display("FAIL glitch_next_data got %h exp 3c", hs_at(hs0)); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int hs0, fe0, ov0;
        hs0 = hs_q.size(); fe0 = fe_total; ov0 = ov_total;
        ready = 1'b1;
        send_byte(8'h55, 1'b0, 30, -1);
        total_cnt++; if (fe_total - fe0 !== 1) $display("FAIL ferr_pulse got %0d exp 1", fe_total - fe0); else pass_cnt++;
        total_cnt++; if (hs_q.size() - hs0 !== 0) $display("FAIL ferr_no_valid got %0d exp 0", hs_q.size() - hs0); else pass_cnt++;
        idle(20);
        send_byte(8'h12, 1'b1, 10, -1);
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 1) $display("FAIL ferr_next_count got %0d exp 1", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'h12) $display("FAIL ferr_next_data got %h exp 12", hs_at(hs0)); else pass_cnt++;
        total_cnt++; if (fe_total - fe0 !== 1 || ov_total - ov0 !== 0)
            $display("FAIL ferr_totals got fe=%0d ov=%0d exp fe=1 ov=0", fe_total - fe0, ov_total - ov0); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int hs0, fe0, ov0;
        hs0 = hs_q.size(); fe0 = fe_total; ov0 = ov_total;
        ready = 1'b0;
        send_byte(8'h11, 1'b1, 10, -1);
        send_byte(8'h22, 1'b1, 10, -1);
        idle(20);
        total_cnt++; if (valid !== 1'b1) $display("FAIL ovr_valid got %b exp 1", valid); else pass_cnt++;
        total_cnt++; if (data !== 8'h11) $display("FAIL ovr_data_held got %h exp 11", data); else pass_cnt++;
        total_cnt++; if (ov_total - ov0 !== 1) $display("FAIL ovr_pulse got %0d exp 1", ov_total - ov0); else pass_cnt++;
        total_cnt++; if (hs_q.size() - hs0 !== 0) $display("FAIL ovr_no_accept got %0d exp 0", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (fe_total - fe0 !== 0) $display("FAIL ovr_frame_err got %0d exp 0", fe_total - fe0); else pass_cnt++;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        total_cnt++; if (valid !== 1'b0) $display("FAIL ovr_drain_valid got %b exp 0", valid); else pass_cnt++;
        total_cnt++; if (hs_q.size() - hs0 !== 1) $display("FAIL ovr_drain_count got %0d exp 1", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'h11) $display("FAIL ovr_drain_data got %h exp 11", hs_at(hs0)); else pass_cnt++;
        total_cnt++; if (stab_total !== 0 || both_total !== 0)
            $display("FAIL ovr_stability got stab=%0d both=%0d exp 0 0", stab_total, both_total); else pass_cnt++;
    endtask

    task automatic test_ready_at_deliver();
        int hs0, ov0;
        hs0 = hs_q.size(); ov0 = ov_total;
        ready = 1'b0;
        send_byte(8'h11, 1'b1, 10, -1);
        send_byte(8'h22, 1'b1, 10, 97);
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 1) $display("FAIL rad_count got %0d exp 1", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'h11) $display("FAIL rad_accepted got %h exp 11", hs_at(hs0)); else pass_cnt++;
        total_cnt++; if (valid !== 1'b1 || data !== 8'h22)
            $display("FAIL rad_new got valid=%b data=%h exp 1 22", valid, data); else pass_cnt++;
        total_cnt++; if (ov_total - ov0 !== 0) $display("FAIL rad_overrun got %0d exp 0", ov_total - ov0); else pass_cnt++;
    endtask

    // Reset lands late in bit 4 so the post-reset low tail is too short to pass the start check.
    task automatic test_reset_mid();
        int hs0, fe0, ov0;
        logic [7:0] bv;
        bv = 8'hE5;
        ready = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (t < 10) rx = 1'b0;
            else if (t < 90) rx = bv[(t - 10) / 10];
            else rx = 1'b1;
            if (t == 57) rst = 1'b1;
            tick();
            if (t == 57) begin
                rst = 1'b0;
                total_cnt++; if (valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", valid); else pass_cnt++;
                total_cnt++; if (data !== 8'h00) $display("FAIL rmid_data got %h exp 00", data); else pass_cnt++;
                total_cnt++; if (frame_err !== 1'b0 || overrun !== 1'b0)
                    $display("FAIL rmid_pulses got fe=%b ov=%b exp 0 0", frame_err, overrun); else pass_cnt++;
                hs0 = hs_q.size(); fe0 = fe_total; ov0 = ov_total;
                ready = 1'b1;
            end
        end
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 0) $display("FAIL rmid_no_partial got %0d exp 0", hs_q.size() - hs0); else pass_cnt++;
        send_byte(8'h7E, 1'b1, 10, -1);
        idle(20);
        total_cnt++; if (hs_q.size() - hs0 !== 1) $display("FAIL rmid_next_count got %0d exp 1", hs_q.size() - hs0); else pass_cnt++;
        total_cnt++; if (hs_at(hs0) !== 8'h7E) $display("FAIL rmid_next_data got %h exp 7e", hs_at(hs0)); else pass_cnt++;
        total_cnt++; if (fe_total - fe0 !== 0 || ov_total - ov0 !== 0)
            $display("FAIL rmid_pulse_totals got fe=%0d ov=%0d exp 0 0", fe_total - fe0, ov_total - ov0); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_ready_at_deliver();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx, sharing the same CLK_HZ/BAUD divider rule.
- Oversamples the asynchronous rx line with the system clock, recovers LSB-first bytes, and presents each byte on a valid/ready output handshake.
- Flags framing errors and overruns; sits between the board rx pin and the byte-stream consumer (command parser / FIFO).

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 921600, line bit rate.
- Derived: DIV = (CLK_HZ + BAUD/2) / BAUD (rounded clocks per bit); HALF = DIV/2 (integer).
- Derived: counter width = clog2(DIV+1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  received byte, stable while valid=1.
- valid  output  1  byte available.
- ready  input  1  consumer accepts data when valid&&ready at a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because valid was still held.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values:
  - data=8'h00, valid=0, frame_err=0, overrun=0.
  - 2-flop rx synchronizer both =1; rx_s is the synchronizer output.
  - cnt=0, bit_idx=0, state=WAIT_HI.
- Reset asserted mid-frame: all of the above on the next edge. Any partial byte is discarded; no pulses are generated.
- States:
  - WAIT_HI: stay until rx_s==1, then go to IDLE. Guarantees no false start after reset or after a break/framing error.
  - IDLE: on rx_s==0, go to START with cnt=HALF-1.
  - START: decrement cnt to 0. At cnt==0:
    - rx_s==0: go to DATA, cnt=DIV-1, bit_idx=0.
    - rx_s==1: treat as a glitch and return to IDLE silently.
  - DATA: decrement cnt to 0. At cnt==0:
    - shreg[bit_idx] <= rx_s (LSB first), cnt=DIV-1.
    - bit_idx==7: go to STOP; otherwise bit_idx++.
  - STOP: decrement cnt to 0. At cnt==0:
    - rx_s==1: deliver byte, go to IDLE.
    - rx_s==0: frame_err=1 for one cycle, discard byte, go to WAIT_HI.
- Sampling: each data bit and the stop bit are sampled at mid-bit, nominally HALF + k*DIV clocks after the synchronized falling edge.
- Deliver, registered, effective the cycle after the stop-bit sample:
  - valid==0, or valid&&ready in the same cycle: data<=shreg, valid<=1, overrun=0.
  - valid==1 && ready==0: keep the old data; new byte dropped; overrun=1 for one cycle.
- Handshake:
  - valid&&ready with no simultaneous deliver: valid<=0 next cycle.
  - data must not change while valid=1 && ready=0.
- Latency: rx falling edge to valid rising is 2 (sync) + 1 (IDLE detect) + HALF + 8*DIV + DIV + 1 clocks, ±1.
- frame_err and overrun are never asserted in the same cycle as each other; both are 0 at all other times.
- Counter: decrement only. No wrap; it is always reloaded before reaching 0-1.

Test Plan:
- Use CLK_HZ=1000000, BAUD=100000 (DIV=10, HALF=5) for all directed tests.
- Byte 0xA5, ready tied 1 -> valid pulses once with data=0xA5; frame_err=0, overrun=0.
- Bytes 0x00 then 0xFF back-to-back (stop bit then immediate start) -> two valids, data 0x00 then 0xFF; idle line between bytes is not required.
- rx low for 3 clocks then high (glitch) -> FSM returns to IDLE; no valid, no frame_err. A following 0x3C is then received correctly.
- Byte 0x55 with stop bit driven 0, rx held 0 for 30 clocks, then a normal 0x12 -> one frame_err pulse, no valid for 0x55; 0x12 received after rx goes high.
- ready=0, send 0x11 then 0x22 -> valid=1 with data=0x11 held; one overrun pulse at the 0x22 stop sample; raising ready yields 0x11 only.
- Same sequence with ready raised in exactly the cycle 0x22 delivers -> 0x11 is accepted, data=0x22 with valid still 1, no overrun.
- rst pulsed at bit 4 of a frame while rx is low -> outputs at reset values; no byte from the remaining bits; next full frame 0x7E is received.
